dma_read_sequencer: RTL and testbench

- Controller that turns one DMA read command into a stream of cache-line read requests, then returns the responses to the consumer.
- The command is a start pulse with a base cache-line address and a line count.
- Sits between a `dma_read_interface` `at_dma` endpoint and the host shell read channel.
- Splits the transfer into aligned 1/2/4-line bursts, throttles on shell almost-full and on consumer prefetch credits, and reports idle/active/done status.

---
 rtl/dma_read_sequencer.sv | 121 ++++++++++++
 tb/tb_dma_read_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_read_sequencer.sv
// DMA read sequencer: turns one read command into aligned 1/2/4-line shell
// requests, throttled by shell almost-full and consumer credits, and forwards responses.
module dma_read_sequencer #(
  parameter int CLADDR_WIDTH   = 42,
  parameter int CLDATA_WIDTH   = 512,
  parameter int LINES_WIDTH    = 32,
  parameter int PREFETCH_DEPTH = 496
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ctrl_start,
  input  logic [CLADDR_WIDTH-1:0] ctrl_addr,
  input  logic [LINES_WIDTH-1:0]  ctrl_num_lines,
  output logic                    status_idle,
  output logic                    status_active,
  output logic                    status_done,
  output logic                    tx_re,
  output logic [CLADDR_WIDTH-1:0] tx_raddr,
  output logic [1:0]              tx_rlength,
  input  logic                    host_almostfull,
  input  logic                    rx_rvalid,
  input  logic [CLDATA_WIDTH-1:0] rx_rdata,
  output logic                    out_rvalid,
  output logic [CLDATA_WIDTH-1:0] out_rdata,
  input  logic                    credit_return
);
  localparam int CRED_W = $clog2(PREFETCH_DEPTH + 1);
  localparam logic [CRED_W:0]   CRED_MAX  = (CRED_W + 1)'(PREFETCH_DEPTH);
  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(PREFETCH_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CLADDR_WIDTH-1:0] cur_addr;
  logic [LINES_WIDTH-1:0]  num_lines, remaining, received, received_nxt;
  logic [CRED_W-1:0]       credits;
  logic [2:0]              burst;
  logic [1:0]              burst_code;
  logic                    issue, last_issue, rsp_accept;

  // Credits never exceed the consumer buffer size; surplus returns are dropped.
  function automatic logic [CRED_W-1:0] credit_sat(input logic [CRED_W:0] val);
    return (val > CRED_MAX) ? CRED_FULL : val[CRED_W-1:0];
  endfunction

  always_comb begin
    burst      = 3'd0;
    burst_code = 2'b00;
    if (state == ISSUE && !host_almostfull) begin
      if (cur_addr[1:0] == 2'b00 && remaining >= LINES_WIDTH'(4) && credits >= CRED_W'(4)) begin
        burst      = 3'd4;
        burst_code = 2'b11;
      end else if (!cur_addr[0] && remaining >= LINES_WIDTH'(2) && credits >= CRED_W'(2)) begin
        burst      = 3'd2;
        burst_code = 2'b01;
      end else if (credits >= CRED_W'(1)) begin
        burst      = 3'd1;
        burst_code = 2'b00;
      end
    end
  end

  assign issue        = (burst != 3'd0);
  assign last_issue   = issue && (remaining == LINES_WIDTH'(burst));
  assign rsp_accept   = rx_rvalid && (state == ISSUE || state == DRAIN);
  assign received_nxt = received + LINES_WIDTH'(rsp_accept);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (ctrl_start) state_nxt = (ctrl_num_lines == '0) ? DONE : ISSUE;
      ISSUE: if (last_issue) state_nxt = DRAIN;
      DRAIN: if (received_nxt == num_lines) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request and response stage: every output is registered off this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      num_lines  <= '0;
      remaining  <= '0;
      received   <= '0;
      credits    <= CRED_FULL;
      tx_re      <= 1'b0;
      tx_raddr   <= '0;
      tx_rlength <= 2'b00;
      out_rvalid <= 1'b0;
      out_rdata  <= '0;
    end else begin
      state   <= state_nxt;
      credits <= credit_sat({1'b0, credits} - (CRED_W + 1)'(burst) + (CRED_W + 1)'(credit_return));
      tx_re   <= issue;
      if (issue) begin
        tx_raddr   <= cur_addr;
        tx_rlength <= burst_code;
        cur_addr   <= cur_addr + CLADDR_WIDTH'(burst);
        remaining  <= remaining - LINES_WIDTH'(burst);
      end
      out_rvalid <= rsp_accept;
      if (rsp_accept) begin
        out_rdata <= rx_rdata;
        received  <= received_nxt;
      end
      if (state == IDLE && ctrl_start) begin
        cur_addr  <= ctrl_addr;
        num_lines <= ctrl_num_lines;
        remaining <= ctrl_num_lines;
        received  <= '0;
      end
    end
  end

  assign status_idle   = (state == IDLE);
  assign status_active = (state == ISSUE) || (state == DRAIN);
  assign status_done   = (state == DONE);

endmodule

// File: tb/tb_dma_read_sequencer.sv
// Bench for dma_read_sequencer: directed scenarios plus randomized transfers,
// all checked cycle by cycle against a transaction-level reference model.
module tb_dma_read_sequencer;
  localparam int AW = 12, DW = 32, LW = 16, PD = 16;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          ctrl_start = 1'b0;
  logic [AW-1:0] ctrl_addr = '0;
  logic [LW-1:0] ctrl_num_lines = '0;
  logic          status_idle, status_active, status_done;
  logic          tx_re;
  logic [AW-1:0] tx_raddr;
  logic [1:0]    tx_rlength;
  logic          host_almostfull = 1'b0;
  logic          rx_rvalid = 1'b0;
  logic [DW-1:0] rx_rdata = '0;
  logic          out_rvalid;
  logic [DW-1:0] out_rdata;
  logic          credit_return = 1'b0;

  always #5 clk = ~clk;

  dma_read_sequencer #(.CLADDR_WIDTH(AW), .CLDATA_WIDTH(DW), .LINES_WIDTH(LW),
                       .PREFETCH_DEPTH(PD)) dut (
    .clk(clk), .reset_n(reset_n), .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr),
    .ctrl_num_lines(ctrl_num_lines), .status_idle(status_idle),
    .status_active(status_active), .status_done(status_done), .tx_re(tx_re),
    .tx_raddr(tx_raddr), .tx_rlength(tx_rlength), .host_almostfull(host_almostfull),
    .rx_rvalid(rx_rvalid), .rx_rdata(rx_rdata), .out_rvalid(out_rvalid),
    .out_rdata(out_rdata), .credit_return(credit_return));

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: transfer bookkeeping in plain integers.
  int            m_phase = 0;  // 0 idle, 1 issuing, 2 draining, 3 done
  logic [AW-1:0] m_addr = '0;
  longint        m_rem = 0, m_num = 0, m_rcv = 0;
  int            m_cred = PD, m_b = 0;
  logic          e_re = 1'b0, e_ov = 1'b0;
  logic [AW-1:0] e_raddr = '0;
  logic [1:0]    e_len = 2'b00;
  logic [DW-1:0] e_od = '0;
  int            cyc = 0;

  function automatic int pick_burst(input logic [AW-1:0] a, input longint rem, input int cred);
    for (int b = 4; b >= 1; b = b / 2)
      if ((int'(a) % b) == 0 && b <= rem && b <= cred) return b;
    return 0;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_cred = PD; m_addr = '0; m_rem = 0; m_num = 0; m_rcv = 0;
      e_re = 1'b0; e_raddr = '0; e_len = 2'b00; e_ov = 1'b0; e_od = '0;
    end else begin
      e_re = 1'b0;
      e_ov = 1'b0;
      if ((m_phase == 1 || m_phase == 2) && rx_rvalid) begin
        e_ov = 1'b1; e_od = rx_rdata; m_rcv++;
      end
      case (m_phase)
        0: if (ctrl_start) begin
             m_addr = ctrl_addr; m_num = ctrl_num_lines; m_rem = ctrl_num_lines; m_rcv = 0;
             m_phase = (ctrl_num_lines == 0) ? 3 : 1;
           end
        1: if (!host_almostfull) begin
             m_b = pick_burst(m_addr, m_rem, m_cred);
             if (m_b > 0) begin
               e_re = 1'b1; e_raddr = m_addr;
               e_len = (m_b == 4) ? 2'b11 : (m_b == 2) ? 2'b01 : 2'b00;
               m_addr = m_addr + AW'(m_b); m_rem -= m_b; m_cred -= m_b;
               if (m_rem == 0) m_phase = 2;
             end
           end
        2: if (m_rcv == m_num) m_phase = 3;
        default: m_phase = 0;
      endcase
      if (credit_return && m_cred < PD) m_cred++;
    end
  end

  int done_cnt = 0, ov_cnt = 0;

  always @(negedge clk) begin
    check("tx_re", tx_re, e_re);
    if (e_re) begin
      check("tx_raddr", tx_raddr, e_raddr);
      check("tx_rlength", tx_rlength, e_len);
    end
    check("out_rvalid", out_rvalid, e_ov);
    if (e_ov) check("out_rdata", out_rdata, e_od);
    check("status_idle", status_idle, m_phase == 0);
    check("status_active", status_active, m_phase == 1 || m_phase == 2);
    check("status_done", status_done, m_phase == 3);
    if (status_done) done_cnt++;
    if (out_rvalid) ov_cnt++;
  end

  // Shell responder, consumer credits and backpressure driver.
  int resp_delay = 3, af_hold = 0, cr_pulse_left = 0;
  bit cr_en = 0, af_rand = 0, gap_en = 0, stray = 0;
  int rq[$];
  int lg_addr[$], lg_len[$], lg_cyc[$];

  always @(negedge clk) begin
    if (!reset_n) rq.delete();
    else if (tx_re) begin
      lg_addr.push_back(int'(tx_raddr));
      lg_len.push_back(tx_rlength == 2'b11 ? 4 : tx_rlength == 2'b01 ? 2 : 1);
      lg_cyc.push_back(cyc);
      for (int i = 0; i < lg_len[$]; i++) rq.push_back(cyc + resp_delay);
    end
    rx_rdata = $urandom;
    if (reset_n && rq.size() > 0 && rq[0] <= cyc && !(gap_en && $urandom_range(3) == 0)) begin
      rx_rvalid = 1'b1;
      void'(rq.pop_front());
    end else rx_rvalid = stray;
    if (cr_pulse_left > 0) begin credit_return = 1'b1; cr_pulse_left--; end
    else credit_return = cr_en && ($urandom_range(1) == 1);
    if (af_hold > 0) begin host_almostfull = 1'b1; af_hold--; end
    else host_almostfull = af_rand && ($urandom_range(3) == 0);
  end

  task automatic start_cmd(input logic [AW-1:0] a, input int n);
    @(negedge clk); #1;
    ctrl_start = 1'b1; ctrl_addr = a; ctrl_num_lines = LW'(n);
    @(negedge clk); #1;
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin @(negedge clk); #1; k++; end
    check(tag, done_cnt != d0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    lg_addr.delete(); lg_len.delete(); lg_cyc.delete();
  endtask

  task automatic check_req(input string tag, input int idx, input int a, input int len, input int gap);
    if (idx < lg_addr.size()) begin
      check({tag, "_addr"}, lg_addr[idx], a);
      check({tag, "_len"}, lg_len[idx], len);
      if (gap > 0) check({tag, "_gap"}, lg_cyc[idx] - lg_cyc[idx-1], gap);
    end else check({tag, "_count"}, lg_addr.size(), idx + 1);
  endtask

  int d0, o0, lsz, c0, quiet, sum;

  initial begin
    #2;
    check("rst_tx_re", tx_re, 0);
    check("rst_tx_raddr", tx_raddr, 0);
    check("rst_tx_rlength", tx_rlength, 0);
    check("rst_out_rvalid", out_rvalid, 0);
    check("rst_out_rdata", out_rdata, 0);
    check("rst_idle", status_idle, 1);
    check("rst_active", status_active, 0);
    check("rst_done", status_done, 0);
    idle(2);
    reset_n = 1'b1;
    idle(2);

    // Burst splitting with full credits.
    clear_log(); d0 = done_cnt; o0 = ov_cnt;
    start_cmd(12'h100, 10);
    wait_done("split_done", d0, 200);
    check("split_reqs", lg_addr.size(), 3);
    check_req("split0", 0, 'h100, 4, 0);
    check_req("split1", 1, 'h104, 4, 1);
    check_req("split2", 2, 'h108, 2, 1);
    check("split_lines", ov_cnt - o0, 10);
    cr_pulse_left = 10; idle(14);

    // Unaligned start.
    clear_log(); d0 = done_cnt; o0 = ov_cnt;
    start_cmd(12'h101, 7);
    wait_done("unal_done", d0, 200);
    check_req("unal0", 0, 'h101, 1, 0);
    check_req("unal1", 1, 'h102, 2, 0);
    check_req("unal2", 2, 'h104, 4, 0);
    check("unal_lines", ov_cnt - o0, 7);
    cr_pulse_left = 7; idle(10);

    // Credit throttle: credits run out after PD lines.
    clear_log(); d0 = done_cnt;
    start_cmd(12'h000, 2 * PD);
    idle(25);
    check("thr_reqs", lg_addr.size(), PD / 4);
    idle(10);
    check("thr_stall", lg_addr.size(), PD / 4);
    af_hold = 6; cr_pulse_left = 4;
    idle(16);
    check_req("thr_rel", PD / 4, PD, 4, 0);
    check("thr_rel_only", lg_addr.size(), PD / 4 + 1);
    cr_en = 1;
    wait_done("thr_done", d0, 1000);
    idle(40);

    // Shell backpressure in the middle of issue.
    clear_log(); d0 = done_cnt;
    start_cmd(12'h200, 24);
    @(negedge clk); #1;
    af_hold = 5; c0 = cyc;
    wait_done("bp_done", d0, 1000);
    quiet = 0; sum = 0;
    foreach (lg_cyc[i]) if (lg_cyc[i] >= c0 + 2 && lg_cyc[i] <= c0 + 6) quiet++;
    check("bp_quiet", quiet, 0);
    foreach (lg_addr[i]) begin
      check("bp_contig", lg_addr[i], 'h200 + sum);
      sum += lg_len[i];
    end
    check("bp_total", sum, 24);
    idle(40);

    // Zero length, then a stray response while idle.
    lsz = lg_addr.size(); o0 = ov_cnt;
    start_cmd(12'h055, 0);
    check("zero_done", status_done, 1);
    idle(1);
    check("zero_idle", status_idle, 1);
    check("zero_nore", lg_addr.size(), lsz);
    stray = 1; idle(1); stray = 0; idle(2);
    check("stray_drop", ov_cnt - o0, 0);

    // Second start during issue is ignored.
    clear_log(); d0 = done_cnt; o0 = ov_cnt;
    start_cmd(12'h300, 10);
    start_cmd(12'h000, 3);
    wait_done("ign_done", d0, 1000);
    check_req("ign0", 0, 'h300, 4, 0);
    check("ign_lines", ov_cnt - o0, 10);
    idle(40);

    // Reset in the middle of a transfer.
    cr_en = 0; idle(2);
    start_cmd(12'h400, 30);
    idle(3);
    #1 reset_n = 1'b0;
    #1;
    check("arst_tx_re", tx_re, 0);
    check("arst_tx_raddr", tx_raddr, 0);
    check("arst_out_rvalid", out_rvalid, 0);
    check("arst_idle", status_idle, 1);
    check("arst_active", status_active, 0);
    @(negedge clk); #2 reset_n = 1'b1;
    clear_log(); d0 = done_cnt; o0 = ov_cnt;
    start_cmd(12'h010, 9);
    wait_done("arst_fresh_done", d0, 200);
    check_req("arst0", 0, 'h010, 4, 0);
    check_req("arst1", 1, 'h014, 4, 1);
    check_req("arst2", 2, 'h018, 1, 1);
    check("arst_lines", ov_cnt - o0, 9);

    // Randomized transfers under random throttling.
    cr_en = 1; af_rand = 1; gap_en = 1;
    for (int t = 0; t < 25; t++) begin
      resp_delay = 1 + $urandom_range(4);
      idle(1 + $urandom_range(6));
      d0 = done_cnt;
      start_cmd(($urandom_range(4) == 0) ? AW'(12'hFF8 + $urandom_range(7)) : AW'($urandom),
                $urandom_range(40));
      wait_done("rand_done", d0, 3000);
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
